// File: rtl/program_loader.sv
// Byte-stream program loader: frames of {LEN_HI, LEN_LO, payload words, XOR checksum} written to BRAM port A.
// Optional macro LOADER_PAD_NOP_EN pads addresses N..INSTRUCTION_COUNT-1 with the END word after a good load.
module program_loader #(
  parameter int INSTRUCTION_WIDTH = 32,
  parameter int INSTRUCTION_COUNT = 512,
  localparam int ADDR_W = $clog2(INSTRUCTION_COUNT)
) (
  input  logic                         clk_in,
  input  logic                         rst_n_in,
  input  logic [7:0]                   data_in,
  input  logic                         valid_in,
  output logic                         ready_out,
  input  logic                         clear_in,
  output logic [ADDR_W-1:0]            wr_addr_out,
  output logic [INSTRUCTION_WIDTH-1:0] wr_data_out,
  output logic                         wr_en_out,
  output logic                         done_out,
  output logic                         error_out,
  output logic                         program_valid_out
);

  localparam int BYTES_PER_WORD = INSTRUCTION_WIDTH / 8;
  localparam logic [7:0] LAST_BYTE = 8'(BYTES_PER_WORD - 1);
  localparam logic [16:0] COUNT = 17'(INSTRUCTION_COUNT);
  localparam logic [INSTRUCTION_WIDTH-1:0] END_WORD = {4'b0001, {(INSTRUCTION_WIDTH-4){1'b0}}};

  typedef enum logic [2:0] {
    S_HDR_HI, S_HDR_LO, S_PAYLOAD, S_CHECK, S_FILL, S_DONE, S_ERROR
  } state_t;

  state_t                       state;
  logic [15:0]                  len;
  logic [15:0]                  word_cnt;
  logic [7:0]                   byte_cnt;
  logic [7:0]                   csum;
  logic [INSTRUCTION_WIDTH-1:0] word;
  logic                         xfer;

  assign xfer = valid_in && ready_out;

  // First byte of a word ends up in the top (opcode) byte after BYTES_PER_WORD shifts.
  function automatic logic [INSTRUCTION_WIDTH-1:0] shift_in(
    input logic [INSTRUCTION_WIDTH-1:0] w,
    input logic [7:0]                   b
  );
    logic [INSTRUCTION_WIDTH+7:0] t;
    t = {w, b};
    return t[INSTRUCTION_WIDTH-1:0];
  endfunction

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state             <= S_HDR_HI;
      ready_out         <= 1'b1;
      wr_en_out         <= 1'b0;
      wr_addr_out       <= '0;
      wr_data_out       <= '0;
      done_out          <= 1'b0;
      error_out         <= 1'b0;
      program_valid_out <= 1'b0;
      len               <= '0;
      word_cnt          <= '0;
      byte_cnt          <= '0;
      csum              <= '0;
      word              <= '0;
    end else begin
      wr_en_out <= 1'b0;
      done_out  <= 1'b0;
      case (state)
        S_HDR_HI: if (xfer) begin
          len[15:8]         <= data_in;
          program_valid_out <= 1'b0;
          csum              <= '0;
          word_cnt          <= '0;
          byte_cnt          <= '0;
          state             <= S_HDR_LO;
        end
        S_HDR_LO: if (xfer) begin
          len[7:0] <= data_in;
          if ({1'b0, len[15:8], data_in} > COUNT) begin
            state     <= S_ERROR;
            ready_out <= 1'b0;
            error_out <= 1'b1;
          end else if ({len[15:8], data_in} == 16'd0) begin
            state <= S_CHECK;
          end else begin
            state <= S_PAYLOAD;
          end
        end
        S_PAYLOAD: if (xfer) begin
          word <= shift_in(word, data_in);
          csum <= csum ^ data_in;
          if (byte_cnt == LAST_BYTE) begin
            byte_cnt    <= '0;
            wr_en_out   <= 1'b1;
            wr_data_out <= shift_in(word, data_in);
            wr_addr_out <= word_cnt[ADDR_W-1:0];
            word_cnt    <= word_cnt + 16'd1;
            if (word_cnt == len - 16'd1) state <= S_CHECK;
          end else begin
            byte_cnt <= byte_cnt + 8'd1;
          end
        end
        S_CHECK: if (xfer) begin
          if (data_in == csum) begin
`ifdef LOADER_PAD_NOP_EN
            ready_out <= 1'b0;
            if ({1'b0, len} == COUNT) begin
              state             <= S_DONE;
              done_out          <= 1'b1;
              program_valid_out <= 1'b1;
            end else begin
              state <= S_FILL;
            end
`else
            state             <= S_DONE;
            ready_out         <= 1'b0;
            done_out          <= 1'b1;
            program_valid_out <= 1'b1;
`endif
          end else begin
            state     <= S_ERROR;
            ready_out <= 1'b0;
            error_out <= 1'b1;
          end
        end
`ifdef LOADER_PAD_NOP_EN
        // word_cnt already equals N here, so it doubles as the pad address.
        S_FILL: begin
          if ({1'b0, word_cnt} == COUNT) begin
            state             <= S_DONE;
            done_out          <= 1'b1;
            program_valid_out <= 1'b1;
          end else begin
            wr_en_out   <= 1'b1;
            wr_data_out <= END_WORD;
            wr_addr_out <= word_cnt[ADDR_W-1:0];
            word_cnt    <= word_cnt + 16'd1;
          end
        end
`endif
        S_DONE: begin
          state     <= S_HDR_HI;
          ready_out <= 1'b1;
        end
        S_ERROR: if (clear_in) begin
          state     <= S_HDR_HI;
          ready_out <= 1'b1;
          error_out <= 1'b0;
        end
        default: begin
          state     <= S_HDR_HI;
          ready_out <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Randomized bench for program_loader: frames are scored against a byte-level model of the frame format.
module tb_program_loader;
  localparam int IW = 32;
  localparam int IC = 512;
  localparam int AW = 9;

  logic          clk_in = 1'b0;
  logic          rst_n_in;
  logic [7:0]    data_in;
  logic          valid_in;
  logic          ready_out;
  logic          clear_in;
  logic [AW-1:0] wr_addr_out;
  logic [IW-1:0] wr_data_out;
  logic          wr_en_out;
  logic          done_out;
  logic          error_out;
  logic          program_valid_out;

  program_loader #(.INSTRUCTION_WIDTH(IW), .INSTRUCTION_COUNT(IC)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .data_in(data_in), .valid_in(valid_in),
    .ready_out(ready_out), .clear_in(clear_in), .wr_addr_out(wr_addr_out),
    .wr_data_out(wr_data_out), .wr_en_out(wr_en_out), .done_out(done_out),
    .error_out(error_out), .program_valid_out(program_valid_out)
  );

  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  logic [AW-1:0] w_addr [0:8191];
  logic [IW-1:0] w_data [0:8191];
  int            w_cyc  [0:8191];
  int            w_tot = 0;
  int            done_tot = 0;

  always @(negedge clk_in) begin
    if (wr_en_out) begin
      w_addr[w_tot % 8192] <= wr_addr_out;
      w_data[w_tot % 8192] <= wr_data_out;
      w_cyc[w_tot % 8192]  <= cyc;
      w_tot                <= w_tot + 1;
    end
    if (done_out) done_tot <= done_tot + 1;
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  logic [7:0]    frame_q[$];
  logic [AW-1:0] ea[$];
  logic [IW-1:0] ed[$];
  int            acc_q[$];
  bit            exp_ok;

  // Reference model: derive expected writes and outcome straight from the frame bytes.
  task automatic build_expect();
    int n;
    logic [7:0] cs;
    n = int'({frame_q[0], frame_q[1]});
    ea.delete(); ed.delete();
    exp_ok = 1'b0;
    if (n <= IC) begin
      cs = 8'h00;
      for (int i = 0; i < n; i++) begin
        ea.push_back(AW'(i));
        ed.push_back({frame_q[2+4*i], frame_q[3+4*i], frame_q[4+4*i], frame_q[5+4*i]});
      end
      for (int j = 0; j < 4*n; j++) cs = cs ^ frame_q[2+j];
      exp_ok = (frame_q[2+4*n] == cs);
`ifdef LOADER_PAD_NOP_EN
      if (exp_ok) for (int a = n; a < IC; a++) begin
        ea.push_back(AW'(a));
        ed.push_back(32'h1000_0000);
      end
`endif
    end
  endtask

  task automatic make_frame(input int n, input bit bad);
    logic [7:0] cs, b;
    frame_q.delete();
    frame_q.push_back(8'(n >> 8));
    frame_q.push_back(8'(n));
    cs = 8'h00;
    for (int j = 0; j < 4*n; j++) begin
      b = 8'($urandom_range(0, 255));
      frame_q.push_back(b);
      cs = cs ^ b;
    end
    if (bad) cs = cs ^ 8'($urandom_range(1, 255));
    frame_q.push_back(cs);
  endtask

  task automatic make_frame1();
    frame_q.delete();
    frame_q = '{8'h00, 8'h02, 8'h30, 8'h10, 8'h00, 8'h01, 8'h10, 8'h00, 8'h00, 8'h00, 8'h31};
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap, output int stamp, output bit ok);
    repeat (gap) begin
      @(negedge clk_in);
      valid_in = 1'b0;
    end
    @(negedge clk_in);
    valid_in = 1'b1;
    data_in  = b;
    ok = 1'b0;
    stamp = 0;
    for (int t = 0; t < 64 && !ok; t++) begin
      if (ready_out) ok = 1'b1;
      else @(negedge clk_in);
    end
    if (ok) begin
      @(posedge clk_in);
      #1 stamp = cyc;
    end
  endtask

  task automatic run_frame(input int max_gap);
    int base_w, base_d, n, nw, stamp, gap;
    bit ok;
    build_expect();
    base_w = w_tot;
    base_d = done_tot;
    acc_q.delete();
    n = int'({frame_q[0], frame_q[1]});
    for (int k = 0; k < frame_q.size(); k++) begin
      gap = (max_gap > 0) ? int'($urandom_range(1, max_gap)) : 0;
      send_byte(frame_q[k], gap, stamp, ok);
      chk("xfer", 64'(ok), 64'd1);
      if (!ok) break;
      if (k >= 2 && k < 2 + 4*n && ((k - 2) % 4) == 3) acc_q.push_back(stamp);
    end
    valid_in = 1'b0;
    ok = 1'b0;
    for (int t = 0; t < 1200 && !ok; t++) begin
      @(negedge clk_in);
      if (done_tot != base_d || error_out) ok = 1'b1;
    end
    chk("settle", 64'(ok), 64'd1);
    repeat (3) @(negedge clk_in);
    nw = w_tot - base_w;
    chk("nwr", 64'(nw), 64'(ea.size()));
    for (int i = 0; i < nw && i < ea.size(); i++) begin
      chk($sformatf("addr%0d", i), 64'(w_addr[(base_w+i) % 8192]), 64'(ea[i]));
      chk($sformatf("data%0d", i), 64'(w_data[(base_w+i) % 8192]), 64'(ed[i]));
      if (i < acc_q.size())
        chk($sformatf("lat%0d", i), 64'(w_cyc[(base_w+i) % 8192]), 64'(acc_q[i]));
    end
    chk("done_cnt", 64'(done_tot - base_d), exp_ok ? 64'd1 : 64'd0);
    chk("prog_valid", 64'(program_valid_out), 64'(exp_ok));
    chk("error", 64'(error_out), 64'(!exp_ok));
    chk("ready", 64'(ready_out), 64'(exp_ok));
    if (!exp_ok) begin
      @(negedge clk_in) clear_in = 1'b1;
      @(negedge clk_in) clear_in = 1'b0;
      chk("clr_error", 64'(error_out), 64'd0);
      chk("clr_ready", 64'(ready_out), 64'd1);
      chk("clr_pv", 64'(program_valid_out), 64'd0);
    end
  endtask

  task automatic check_reset_outputs(input string pfx);
    chk({pfx, "_ready"}, 64'(ready_out), 64'd1);
    chk({pfx, "_wr_en"}, 64'(wr_en_out), 64'd0);
    chk({pfx, "_addr"}, 64'(wr_addr_out), 64'd0);
    chk({pfx, "_data"}, 64'(wr_data_out), 64'd0);
    chk({pfx, "_done"}, 64'(done_out), 64'd0);
    chk({pfx, "_err"}, 64'(error_out), 64'd0);
    chk({pfx, "_pv"}, 64'(program_valid_out), 64'd0);
  endtask

  initial begin
    int stamp;
    bit ok;
    rst_n_in = 1'b0;
    valid_in = 1'b0;
    data_in  = 8'h00;
    clear_in = 1'b0;
    repeat (3) @(negedge clk_in);
    check_reset_outputs("rst");
    rst_n_in = 1'b1;
    @(negedge clk_in);

    make_frame1();
    run_frame(0);

    // clear_in outside ERROR must not disturb a loaded program
    @(negedge clk_in) clear_in = 1'b1;
    @(negedge clk_in) clear_in = 1'b0;
    @(negedge clk_in);
    chk("idle_clr_pv", 64'(program_valid_out), 64'd1);
    chk("idle_clr_err", 64'(error_out), 64'd0);

    frame_q = '{8'h00, 8'h00, 8'h00};
    run_frame(0);

    frame_q = '{8'h02, 8'h01};
    run_frame(0);

    make_frame1();
    frame_q[10] = 8'h22;
    run_frame(0);

    make_frame1();
    run_frame(5);

    for (int r = 0; r < 8; r++) begin
      make_frame(int'($urandom_range(1, 8)), ($urandom_range(0, 3) == 0));
      run_frame(int'($urandom_range(0, 5)));
    end

    make_frame(IC, 1'b0);
    run_frame(0);

    // Abort mid-frame after 5 payload bytes
    make_frame1();
    for (int k = 0; k < 7; k++) send_byte(frame_q[k], 0, stamp, ok);
    valid_in = 1'b0;
    #2 rst_n_in = 1'b0;
    #1 check_reset_outputs("mid_rst");
    @(negedge clk_in) rst_n_in = 1'b1;
    @(negedge clk_in);
    make_frame1();
    run_frame(0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
